// File: rtl/ls_queue_pkg.sv
// Shared types for the load/store queue and its entry storage.
// The ls_unit operand pack and the queue entry layout are defined here.
package ls_queue_pkg;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam int LSQ_DEPTH   = 8;

  // read_write: 1 = load, 0 = store
  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] insn_tag;
    logic                   read_write;
    logic [2:0]             mem_size;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        value_src1;
    logic [XLEN-1:0]        value_src2;
  } ls_unit_pack_t;

  typedef struct packed {
    logic                   valid;
    logic                   src1_rdy;
    logic                   src2_rdy;
    logic [ROB_TAG_LEN-1:0] src1_tag;
    logic [ROB_TAG_LEN-1:0] src2_tag;
    ls_unit_pack_t          pack;
  } lsq_entry_t;

  typedef enum logic {
    LSQ_IDLE,
    LSQ_ISSUED
  } lsq_state_e;

  function automatic logic tag_hit(
    input logic                   cdb_valid,
    input logic [ROB_TAG_LEN-1:0] cdb_tag,
    input logic [ROB_TAG_LEN-1:0] src_tag,
    input logic                   src_rdy
  );
    return cdb_valid && !src_rdy && (cdb_tag == src_tag);
  endfunction

endpackage

// File: rtl/ls_queue_entry.sv
// One load/store queue slot: dispatch write, CDB operand capture, clear.
// A CDB hit in the dispatch cycle lands in the freshly written slot.
module lsq_entry
  import ls_queue_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic                   clr,
  input  logic                   flush,
  input  ls_unit_pack_t          wr_pack,
  input  logic                   wr_src1_rdy,
  input  logic                   wr_src2_rdy,
  input  logic [ROB_TAG_LEN-1:0] wr_src1_tag,
  input  logic [ROB_TAG_LEN-1:0] wr_src2_tag,
  input  logic                   cdb_valid,
  input  logic [ROB_TAG_LEN-1:0] cdb_tag,
  input  logic [XLEN-1:0]        cdb_value,
  output logic                   valid,
  output logic                   ops_rdy,
  output ls_unit_pack_t          pack
);

  lsq_entry_t ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      ent_d = '0;
    end else if (wr_en) begin
      ent_d.valid    = 1'b1;
      ent_d.src1_rdy = wr_src1_rdy;
      ent_d.src2_rdy = wr_src2_rdy;
      ent_d.src1_tag = wr_src1_tag;
      ent_d.src2_tag = wr_src2_tag;
      ent_d.pack     = wr_pack;
    end else if (clr) begin
      ent_d = '0;
    end
    if (ent_d.valid &&
        tag_hit(cdb_valid, cdb_tag, ent_d.src1_tag, ent_d.src1_rdy)) begin
      ent_d.pack.value_src1 = cdb_value;
      ent_d.src1_rdy        = 1'b1;
    end
    if (ent_d.valid &&
        tag_hit(cdb_valid, cdb_tag, ent_d.src2_tag, ent_d.src2_rdy)) begin
      ent_d.pack.value_src2 = cdb_value;
      ent_d.src2_rdy        = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ent_q <= '0;
    else          ent_q <= ent_d;
  end

  assign valid   = ent_q.valid;
  assign ops_rdy = ent_q.src1_rdy &&
                   (ent_q.pack.read_write || ent_q.src2_rdy);
  assign pack    = ent_q.pack;

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue feeding ls_unit; one issue held until done.
// Stores issue only as ROB head, so memory is never written speculatively.
module ls_queue
  import ls_queue_pkg::*;
#(
  parameter  int DEPTH = LSQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   dispatch_valid,
  input  ls_unit_pack_t          dispatch_pack,
  input  logic                   src1_ready,
  input  logic [ROB_TAG_LEN-1:0] src1_tag,
  input  logic                   src2_ready,
  input  logic [ROB_TAG_LEN-1:0] src2_tag,
  output logic                   dispatch_ready,
  input  logic                   cdb_valid,
  input  logic [ROB_TAG_LEN-1:0] cdb_tag,
  input  logic [XLEN-1:0]        cdb_value,
  input  logic [ROB_TAG_LEN-1:0] rob_head_tag,
  input  logic                   squash,
  input  logic                   lsu_done,
  output logic                   issue_valid,
  output ls_unit_pack_t          issue_pack,
  output logic [PTR_W:0]         count
);

  logic [PTR_W:0]   head_q, head_d, tail_q, tail_d;
  lsq_state_e       state_q, state_d;
  ls_unit_pack_t    pack_q, pack_d;
  logic             ent_valid [DEPTH];
  logic             ent_rdy   [DEPTH];
  ls_unit_pack_t    ent_pack  [DEPTH];
  logic             push, pop, eligible;
  logic [PTR_W-1:0] head_idx, tail_idx;

  assign head_idx       = head_q[PTR_W-1:0];
  assign tail_idx       = tail_q[PTR_W-1:0];
  assign count          = tail_q - head_q;
  assign dispatch_ready = (count != (PTR_W+1)'(DEPTH));
  assign push           = dispatch_valid && dispatch_ready && !squash;

  assign eligible = ent_valid[head_idx] && ent_rdy[head_idx] &&
                    (ent_pack[head_idx].read_write ||
                     ent_pack[head_idx].insn_tag == rob_head_tag);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    lsq_entry u_ent (
      .clock       (clock),
      .reset_n     (reset_n),
      .wr_en       (push && tail_idx == PTR_W'(i)),
      .clr         (pop && head_idx == PTR_W'(i)),
      .flush       (squash),
      .wr_pack     (dispatch_pack),
      .wr_src1_rdy (src1_ready),
      .wr_src2_rdy (src2_ready),
      .wr_src1_tag (src1_tag),
      .wr_src2_tag (src2_tag),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_value   (cdb_value),
      .valid       (ent_valid[i]),
      .ops_rdy     (ent_rdy[i]),
      .pack        (ent_pack[i])
    );
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pack_d  = pack_q;
    pop     = 1'b0;
    if (squash) begin
      state_d = LSQ_IDLE;
      head_d  = tail_q;
    end else begin
      if (push) tail_d = tail_q + (PTR_W+1)'(1);
      case (state_q)
        LSQ_IDLE: begin
          if (eligible) begin
            state_d = LSQ_ISSUED;
            pack_d  = ent_pack[head_idx];
          end
        end
        LSQ_ISSUED: begin
          if (lsu_done) begin
            state_d = LSQ_IDLE;
            pop     = 1'b1;
            head_d  = head_q + (PTR_W+1)'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LSQ_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      pack_q  <= pack_d;
    end
  end

  assign issue_valid = (state_q == LSQ_ISSUED);
  assign issue_pack  = pack_q;

endmodule

// File: tb/tb_ls_queue.sv
// Self-checking bench for ls_queue: vector table, corner sequences,
// then random traffic against a queue-level reference model.
module tb_ls_queue;
  import ls_queue_pkg::*;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          dispatch_valid, src1_ready, src2_ready;
  logic [4:0]    src1_tag, src2_tag, cdb_tag, rob_head_tag;
  ls_unit_pack_t dispatch_pack, issue_pack;
  logic          dispatch_ready, cdb_valid, squash, lsu_done;
  logic [31:0]   cdb_value;
  logic          issue_valid;
  logic [3:0]    count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ls_queue dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .dispatch_valid (dispatch_valid),
    .dispatch_pack  (dispatch_pack),
    .src1_ready     (src1_ready),
    .src1_tag       (src1_tag),
    .src2_ready     (src2_ready),
    .src2_tag       (src2_tag),
    .dispatch_ready (dispatch_ready),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .rob_head_tag   (rob_head_tag),
    .squash         (squash),
    .lsu_done       (lsu_done),
    .issue_valid    (issue_valid),
    .issue_pack     (issue_pack),
    .count          (count)
  );

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic disp(bit v, bit rw, logic [4:0] tag,
                      bit s1r, logic [4:0] t1, logic [31:0] v1,
                      bit s2r, logic [4:0] t2, logic [31:0] v2);
    dispatch_valid            = v;
    dispatch_pack             = '0;
    dispatch_pack.insn_tag    = tag;
    dispatch_pack.read_write  = rw;
    dispatch_pack.mem_size    = 3'd2;
    dispatch_pack.imm         = 32'd4;
    dispatch_pack.value_src1  = v1;
    dispatch_pack.value_src2  = v2;
    src1_ready = s1r;
    src1_tag   = t1;
    src2_ready = s2r;
    src2_tag   = t2;
  endtask

  task automatic cdb(bit v, logic [4:0] t, logic [31:0] val);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_value = val;
  endtask

  task automatic quiet();
    disp(0, 1, 0, 1, 0, 0, 1, 0, 0);
    cdb(0, 0, 0);
    lsu_done = 1'b0;
    squash   = 1'b0;
  endtask

  task automatic wait_iv(string name);
    int c = 0;
    while (!issue_valid && c < 20) begin
      step();
      c++;
    end
    chk(name, issue_valid, 1);
  endtask

  typedef struct {
    bit          dv, rw, s1r, s2r;
    logic [4:0]  tag, t1;
    logic [31:0] v1;
    bit          cv;
    logic [4:0]  ct;
    logic [31:0] cval;
    logic [4:0]  rh;
    bit          done;
    bit          e_iv;
    int          e_cnt;
    logic [4:0]  e_tag;
    logic [31:0] e_v1;
  } vec_t;

  function automatic vec_t mk(bit dv, bit rw, logic [4:0] tag, bit s1r,
                              logic [4:0] t1, logic [31:0] v1, bit s2r,
                              bit cv, logic [4:0] ct, logic [31:0] cval,
                              logic [4:0] rh, bit done, bit e_iv,
                              int e_cnt, logic [4:0] e_tag,
                              logic [31:0] e_v1);
    vec_t v;
    v.dv = dv; v.rw = rw; v.tag = tag; v.s1r = s1r; v.t1 = t1;
    v.v1 = v1; v.s2r = s2r; v.cv = cv; v.ct = ct; v.cval = cval;
    v.rh = rh; v.done = done; v.e_iv = e_iv; v.e_cnt = e_cnt;
    v.e_tag = e_tag; v.e_v1 = e_v1;
    return v;
  endfunction

  typedef struct {
    ls_unit_pack_t p;
    bit            r1, r2;
    logic [4:0]    t1, t2;
  } ment_t;

  ment_t         mq[$];
  bit            m_busy;
  ls_unit_pack_t m_pack;

  initial begin
    vec_t vt[21];
    // ready load, held 3 cycles, done
    vt[0]  = mk(1,1,1,1,0,'h100,1, 0,0,0, 0,0, 0,1,0,0);
    vt[1]  = mk(0,1,0,1,0,0,1,     0,0,0, 0,0, 1,1,1,'h100);
    vt[2]  = mk(0,1,0,1,0,0,1,     0,0,0, 0,0, 1,1,1,'h100);
    vt[3]  = mk(0,1,0,1,0,0,1,     0,0,0, 0,0, 1,1,1,'h100);
    vt[4]  = mk(0,1,0,1,0,0,1,     0,0,0, 0,1, 0,0,0,0);
    // src1 captured from CDB two cycles after dispatch
    vt[5]  = mk(1,1,2,0,5,'hdead,1, 0,0,0, 0,0, 0,1,0,0);
    vt[6]  = mk(0,1,0,1,0,0,1,      0,0,0, 0,0, 0,1,0,0);
    vt[7]  = mk(0,1,0,1,0,0,1,      1,5,'h2000, 0,0, 0,1,0,0);
    vt[8]  = mk(0,1,0,1,0,0,1,      0,0,0, 0,0, 1,1,2,'h2000);
    vt[9]  = mk(0,1,0,1,0,0,1,      0,0,0, 0,1, 0,0,0,0);
    // CDB bypass in the dispatch cycle
    vt[10] = mk(1,1,3,0,5,'hdead,1, 1,5,'h3000, 0,0, 0,1,0,0);
    vt[11] = mk(0,1,0,1,0,0,1,      0,0,0, 0,0, 1,1,3,'h3000);
    vt[12] = mk(0,1,0,1,0,0,1,      0,0,0, 0,1, 0,0,0,0);
    // store waits for ROB head; younger load stays behind
    vt[13] = mk(1,0,3,1,0,'h40,1, 0,0,0, 2,0, 0,1,0,0);
    vt[14] = mk(1,1,4,1,0,'h50,1, 0,0,0, 2,0, 0,2,0,0);
    vt[15] = mk(0,1,0,1,0,0,1,    0,0,0, 2,0, 0,2,0,0);
    vt[16] = mk(0,1,0,1,0,0,1,    0,0,0, 3,0, 1,2,3,'h40);
    vt[17] = mk(0,1,0,1,0,0,1,    0,0,0, 9,0, 1,2,3,'h40);
    vt[18] = mk(0,1,0,1,0,0,1,    0,0,0, 9,1, 0,1,0,0);
    vt[19] = mk(0,1,0,1,0,0,1,    0,0,0, 9,0, 1,1,4,'h50);
    vt[20] = mk(0,1,0,1,0,0,1,    0,0,0, 9,1, 0,0,0,0);

    reset_n      = 1'b0;
    rob_head_tag = '0;
    quiet();
    repeat (2) @(negedge clock);
    chk("rst_iv", issue_valid, 0);
    chk("rst_cnt", count, 0);
    chk("rst_rdy", dispatch_ready, 1);
    chk("rst_pack", issue_pack, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      disp(vt[i].dv, vt[i].rw, vt[i].tag, vt[i].s1r, vt[i].t1,
           vt[i].v1, vt[i].s2r, 0, 32'haa);
      cdb(vt[i].cv, vt[i].ct, vt[i].cval);
      rob_head_tag = vt[i].rh;
      lsu_done     = vt[i].done;
      squash       = 1'b0;
      step();
      chk($sformatf("vec%0d_iv", i), issue_valid, vt[i].e_iv);
      chk($sformatf("vec%0d_cnt", i), count, vt[i].e_cnt);
      chk($sformatf("vec%0d_rdy", i), dispatch_ready, vt[i].e_cnt < 8);
      if (vt[i].e_iv) begin
        chk($sformatf("vec%0d_tag", i), issue_pack.insn_tag, vt[i].e_tag);
        chk($sformatf("vec%0d_v1", i), issue_pack.value_src1, vt[i].e_v1);
      end
    end
    quiet();

    // async reset mid-issue
    disp(1, 1, 6, 1, 0, 32'h600, 1, 0, 0);
    step();
    quiet();
    step();
    chk("ar_pre_iv", issue_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_iv", issue_valid, 0);
    chk("ar_cnt", count, 0);
    chk("ar_rdy", dispatch_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;

    // fill, drop when full, wrap tail, drain in order
    for (int i = 0; i < 8; i++) begin
      disp(1, 1, 5'(i), 0, 7, 0, 1, 0, 0);
      step();
    end
    chk("full_cnt", count, 8);
    chk("full_rdy", dispatch_ready, 0);
    disp(1, 1, 20, 1, 0, 32'h20, 1, 0, 0);
    step();
    chk("drop_cnt", count, 8);
    chk("drop_iv", issue_valid, 0);
    quiet();
    cdb(1, 7, 32'h77);
    step();
    quiet();
    chk("cap_iv", issue_valid, 0);
    step();
    chk("h0_iv", issue_valid, 1);
    chk("h0_tag", issue_pack.insn_tag, 0);
    chk("h0_v1", issue_pack.value_src1, 32'h77);
    lsu_done = 1'b1;
    step();
    lsu_done = 1'b0;
    chk("pop_cnt", count, 7);
    chk("pop_rdy", dispatch_ready, 1);
    disp(1, 1, 8, 1, 0, 32'h88, 1, 0, 0);
    step();
    quiet();
    chk("wrap_cnt", count, 8);
    chk("wrap_rdy", dispatch_ready, 0);
    for (int k = 1; k <= 8; k++) begin
      wait_iv($sformatf("drain%0d_iv", k));
      chk($sformatf("drain%0d_tag", k), issue_pack.insn_tag, k);
      lsu_done = 1'b1;
      step();
      lsu_done = 1'b0;
    end
    chk("drain_cnt", count, 0);

    // squash while issued, then stray done
    for (int i = 0; i < 4; i++) begin
      disp(1, 1, 5'(10 + i), 1, 0, 32'(i), 1, 0, 0);
      step();
    end
    quiet();
    wait_iv("sq_pre_iv");
    chk("sq_pre_cnt", count, 4);
    squash = 1'b1;
    step();
    squash = 1'b0;
    chk("sq_iv", issue_valid, 0);
    chk("sq_cnt", count, 0);
    lsu_done = 1'b1;
    step();
    lsu_done = 1'b0;
    chk("sqd_iv", issue_valid, 0);
    chk("sqd_cnt", count, 0);
    disp(1, 1, 14, 1, 0, 32'h14, 1, 0, 0);
    step();
    quiet();
    step();
    chk("post_sq_iv", issue_valid, 1);
    chk("post_sq_tag", issue_pack.insn_tag, 14);
    lsu_done = 1'b1;
    step();
    quiet();
    chk("post_sq_cnt", count, 0);

    // random traffic against the reference model
    begin
      logic [4:0] seq = 5'd16;
      mq.delete();
      m_busy = 1'b0;
      m_pack = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        bit            dv, rw, s1r, s2r, elig, acc;
        logic [4:0]    t1, t2;
        logic [31:0]   v1, v2;
        ls_unit_pack_t snap;
        ment_t         ne;
        dv  = $urandom_range(0, 99) < 60;
        rw  = $urandom_range(0, 2) != 0;
        s1r = 1'($urandom);
        s2r = 1'($urandom);
        t1  = 5'($urandom_range(0, 7));
        t2  = 5'($urandom_range(0, 7));
        v1  = $urandom;
        v2  = $urandom;
        disp(dv, rw, seq, s1r, t1, v1, s2r, t2, v2);
        seq++;
        cdb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          rob_head_tag = mq[0].p.insn_tag;
        else
          rob_head_tag = 5'($urandom);
        lsu_done = 1'($urandom);
        squash   = $urandom_range(0, 49) == 0;

        if (squash) begin
          mq.delete();
          m_busy = 1'b0;
        end else begin
          elig = 1'b0;
          snap = '0;
          if (mq.size() > 0) begin
            snap = mq[0].p;
            elig = mq[0].r1 && (mq[0].p.read_write || mq[0].r2) &&
                   (mq[0].p.read_write ||
                    mq[0].p.insn_tag == rob_head_tag);
          end
          acc = dispatch_valid && mq.size() < 8;
          foreach (mq[k]) begin
            if (cdb_valid && !mq[k].r1 && mq[k].t1 == cdb_tag) begin
              mq[k].r1 = 1'b1;
              mq[k].p.value_src1 = cdb_value;
            end
            if (cdb_valid && !mq[k].r2 && mq[k].t2 == cdb_tag) begin
              mq[k].r2 = 1'b1;
              mq[k].p.value_src2 = cdb_value;
            end
          end
          if (m_busy && lsu_done) begin
            void'(mq.pop_front());
            m_busy = 1'b0;
          end else if (!m_busy && elig) begin
            m_busy = 1'b1;
            m_pack = snap;
          end
          if (acc) begin
            ne.p  = dispatch_pack;
            ne.r1 = s1r;
            ne.r2 = s2r;
            ne.t1 = t1;
            ne.t2 = t2;
            if (cdb_valid && !s1r && t1 == cdb_tag) begin
              ne.r1 = 1'b1;
              ne.p.value_src1 = cdb_value;
            end
            if (cdb_valid && !s2r && t2 == cdb_tag) begin
              ne.r2 = 1'b1;
              ne.p.value_src2 = cdb_value;
            end
            mq.push_back(ne);
          end
        end
        step();
        chk($sformatf("rnd%0d_iv", cyc), issue_valid, m_busy);
        chk($sformatf("rnd%0d_cnt", cyc), count, mq.size());
        chk($sformatf("rnd%0d_rdy", cyc), dispatch_ready, mq.size() < 8);
        if (m_busy)
          chk($sformatf("rnd%0d_pack", cyc), issue_pack, m_pack);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
